// File: rtl/main_memory_responder.sv
// main_memory_responder: backing-store model on the memory side of the cache
// interface. It accepts one word read or write at a time, waits a fixed
// LATENCY, and then pulses mem_ready for one cycle. Read data stays on
// mem_data_out until the next read completes.
// Optional build macro MEM_BYTE_MASK_EN adds the mem_be byte-enable input.
module main_memory_responder #(
  parameter int MEM_WORDS_LOG2 = 12,
  parameter int LATENCY        = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             mem_req,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [0:3][7:0]  mem_data_in,
`ifdef MEM_BYTE_MASK_EN
  input  logic [3:0]       mem_be,
`endif
  output logic [0:3][7:0]  mem_data_out,
  output logic             mem_ready,
  output logic             mem_busy
);

  localparam int unsigned WORDS  = 1 << MEM_WORDS_LOG2;
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("main_memory_responder: LATENCY must be in 1..255");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
  typedef logic [MEM_WORDS_LOG2-1:0] idx_t;
  typedef logic [0:3][7:0]           word_t;

  word_t      mem_array [WORDS];

  state_e     state_q, state_d;
  logic [7:0] cnt_q,   cnt_d;
  idx_t       idx_q,   idx_d;
  logic       we_q,    we_d;
  word_t      wdata_q, wdata_d;
  logic [3:0] be_q,    be_d;
  word_t      rdata_q, rdata_d;
  logic       ready_q, ready_d;
  logic       busy_q,  busy_d;

  idx_t       req_idx;
  logic [3:0] req_be;
  logic       unused_addr_bits;

  // Byte offset and bits above the word index alias onto the same word.
  assign req_idx          = mem_addr[MEM_WORDS_LOG2+1:2];
  assign unused_addr_bits = ^{mem_addr[31:MEM_WORDS_LOG2+2], mem_addr[1:0]};

`ifdef MEM_BYTE_MASK_EN
  assign req_be = mem_be;
`else
  assign req_be = 4'hF;
`endif

  // Next-state and next-output logic for the IDLE -> WAIT -> RESP sequence.
  always_comb begin
    // NOTE: every _d gets a default of its _q first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          idx_d   = req_idx;
          we_d    = mem_we;
          wdata_d = mem_data_in;
          be_d    = req_be;
          cnt_d   = LAT_M1;
          state_d = (LATENCY > 1) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Read data is fetched on the edge entering RESP so it is valid for the
    // whole ready cycle; the pending write (if any) commits later.
    if (state_d == ST_RESP && state_q != ST_RESP && !we_d) begin
      rdata_d = mem_array[idx_d];
    end

    ready_d = (state_d == ST_RESP);
    busy_d  = (state_d != ST_IDLE);
  end

  // Control state and registered outputs; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_b) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // computed before this edge, independent of statement order.
    if (!rst_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Write commit on the edge leaving RESP, one byte lane per enable bit.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; clearing thousands of words is
    // not part of the behaviour and would prevent RAM inference.
    if (state_q == ST_RESP && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_array[idx_q][i] <= wdata_q[i];
      end
    end
  end

  assign mem_data_out = rdata_q;
  assign mem_ready    = ready_q;
  assign mem_busy     = busy_q;

endmodule
